// File: rtl/fetch_decode_buffer.sv
// Fetch/decode decoupling FIFO of {instr, pc} pairs with flush and a defined bubble
// on the decode side whenever the buffer is empty.
module fetch_decode_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] BUBBLE_INSTR = 'h13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       f_valid,
    input  logic [WIDTH-1:0]           f_instr,
    input  logic [WIDTH-1:0]           f_pc,
    output logic                       f_ready,
    output logic                       d_valid,
    output logic [WIDTH-1:0]           d_instr,
    output logic [WIDTH-1:0]           d_pc,
    output logic [WIDTH-1:0]           d_pcplus4,
    input  logic                       d_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] instrMem [DEPTH];
    logic [WIDTH-1:0] pcMem    [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] occupancy;
    logic             push;
    logic             pop;

    // Handshake: a transfer happens on a side only when its valid and ready are both
    // high at the rising edge and flush is low. f_ready depends only on occupancy
    // (no pass-through when full); d_ready is ignored while d_valid is low.
    assign f_ready = (occupancy < CNT_W'(DEPTH));
    assign d_valid = (occupancy != '0);
    assign push    = f_valid && f_ready && !flush;
    assign pop     = d_valid && d_ready && !flush;
    assign count   = occupancy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= f_instr;
            pcMem[wrPtr]    <= f_pc;
        end
    end

    always_comb begin
        d_instr   = BUBBLE_INSTR;
        d_pc      = '0;
        d_pcplus4 = '0;
        if (d_valid) begin
            d_instr   = instrMem[rdPtr];
            d_pc      = pcMem[rdPtr];
            d_pcplus4 = pcMem[rdPtr] + WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_decode_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_ready;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pcplus4;
    logic        d_ready;
    logic [2:0]  count;

    int numChecks = 0;
    int numFails  = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        fl;
        logic        fv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        dr;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic [31:0] ePc4;
        int          eCount;
        logic        eReady;
    } vec_t;

    vec_t vecs[$];

    fetch_decode_buffer #(.WIDTH(32), .DEPTH(DEPTH), .BUBBLE_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_ready(f_ready),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_pcplus4(d_pcplus4),
        .d_ready(d_ready), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic eValid, input logic [31:0] eInstr,
                                 input logic [31:0] ePc, input logic [31:0] ePc4,
                                 input int eCount, input logic eReady);
        check({tag, ".d_valid"},   32'(d_valid),   32'(eValid));
        check({tag, ".d_instr"},   d_instr,        eInstr);
        check({tag, ".d_pc"},      d_pc,           ePc);
        check({tag, ".d_pcplus4"}, d_pcplus4,      ePc4);
        check({tag, ".count"},     32'(count),     32'(eCount));
        check({tag, ".f_ready"},   32'(f_ready),   32'(eReady));
    endtask

    // driver: inputs set just after a rising edge, outputs sampled on the falling edge
    task automatic drive(input logic fl, input logic fv, input logic [31:0] ins,
                         input logic [31:0] pc, input logic dr);
        flush   = fl;
        f_valid = fv;
        f_instr = ins;
        f_pc    = pc;
        d_ready = dr;
    endtask

    task automatic add_vec(input logic fl, input logic fv, input logic [31:0] ins,
                           input logic [31:0] pc, input logic dr, input logic eValid,
                           input logic [31:0] eInstr, input logic [31:0] ePc,
                           input int eCount, input logic eReady);
        vec_t v;
        v.fl = fl; v.fv = fv; v.ins = ins; v.pc = pc; v.dr = dr;
        v.eValid = eValid; v.eInstr = eInstr; v.ePc = ePc;
        v.ePc4 = eValid ? ePc + 32'd4 : 32'd0;
        v.eCount = eCount; v.eReady = eReady;
        vecs.push_back(v);
    endtask

    // reference model: a plain queue of {instr, pc}, updated at each edge
    task automatic model_cycle(input string tag, input logic fl, input logic fv,
                               input logic [31:0] ins, input logic [31:0] pc, input logic dr);
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic        doPush;
        logic        doPop;
        drive(fl, fv, ins, pc, dr);
        @(negedge clk);
        eValid = (exp_q.size() != 0);
        eInstr = eValid ? exp_q[0][63:32] : 32'h00000013;
        ePc    = eValid ? exp_q[0][31:0]  : 32'd0;
        check_outputs(tag, eValid, eInstr, ePc, eValid ? ePc + 32'd4 : 32'd0,
                      exp_q.size(), exp_q.size() < DEPTH);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            doPop  = (exp_q.size() != 0) && dr;
            doPush = fv && (exp_q.size() < DEPTH);
            if (doPop)  void'(exp_q.pop_front());
            if (doPush) exp_q.push_back({ins, pc});
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        check_outputs("reset", 1'b0, 32'h13, 32'd0, 32'd0, 0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // fill to full, rejected 5th push, drain
        add_vec(0, 1, 32'hA0, 32'h0,  0, 0, 32'h13, 32'h0,  0, 1);
        add_vec(0, 1, 32'hA1, 32'h4,  0, 1, 32'hA0, 32'h0,  1, 1);
        add_vec(0, 1, 32'hA2, 32'h8,  0, 1, 32'hA0, 32'h0,  2, 1);
        add_vec(0, 1, 32'hA3, 32'hC,  0, 1, 32'hA0, 32'h0,  3, 1);
        add_vec(0, 1, 32'hA4, 32'h10, 0, 1, 32'hA0, 32'h0,  4, 0);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hA0, 32'h0,  4, 0);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hA1, 32'h4,  3, 1);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hA2, 32'h8,  2, 1);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hA3, 32'hC,  1, 1);
        add_vec(0, 0, 32'h0,  32'h0,  0, 0, 32'h13, 32'h0,  0, 1);
        // simultaneous push/pop at count=2
        add_vec(0, 1, 32'hB0, 32'h20, 0, 0, 32'h13, 32'h0,  0, 1);
        add_vec(0, 1, 32'hB1, 32'h24, 0, 1, 32'hB0, 32'h20, 1, 1);
        add_vec(0, 1, 32'hB2, 32'h28, 1, 1, 32'hB0, 32'h20, 2, 1);
        add_vec(0, 1, 32'hB3, 32'h2C, 1, 1, 32'hB1, 32'h24, 2, 1);
        add_vec(0, 1, 32'hB4, 32'h30, 1, 1, 32'hB2, 32'h28, 2, 1);
        add_vec(0, 0, 32'h0,  32'h0,  0, 1, 32'hB3, 32'h2C, 2, 1);
        // flush at count=3 with push and pop attempted, then a lone push
        add_vec(0, 1, 32'hB5, 32'h34, 0, 1, 32'hB3, 32'h2C, 2, 1);
        add_vec(1, 1, 32'hC0, 32'h40, 1, 1, 32'hB3, 32'h2C, 3, 1);
        add_vec(0, 1, 32'hD0, 32'h100, 0, 0, 32'h13, 32'h0, 0, 1);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hD0, 32'h100, 1, 1);
        // PC wrap on d_pcplus4, then flush while empty
        add_vec(0, 1, 32'hE0, 32'hFFFFFFFC, 0, 0, 32'h13, 32'h0, 0, 1);
        add_vec(0, 0, 32'h0,  32'h0,  1, 1, 32'hE0, 32'hFFFFFFFC, 1, 1);
        add_vec(1, 0, 32'h0,  32'h0,  0, 0, 32'h13, 32'h0,  0, 1);
        add_vec(0, 0, 32'h0,  32'h0,  0, 0, 32'h13, 32'h0,  0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].fv, vecs[i].ins, vecs[i].pc, vecs[i].dr);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eInstr,
                          vecs[i].ePc, vecs[i].ePc4, vecs[i].eCount, vecs[i].eReady);
            @(posedge clk);
            #1;
        end

        // 10 push/pop pairs across the pointer wrap boundary
        exp_q.delete();
        model_cycle("wrap_prime", 0, 1, 32'h5000, 32'h200, 0);
        for (int i = 0; i < 10; i++)
            model_cycle($sformatf("wrap%0d", i), 0, 1, 32'h5001 + i, 32'h204 + 4 * i, 1);
        model_cycle("wrap_tail", 0, 0, 32'h0, 32'h0, 1);
        model_cycle("wrap_end", 0, 0, 32'h0, 32'h0, 0);

        // async reset mid-cycle at count=3
        for (int i = 0; i < 3; i++)
            model_cycle($sformatf("pre_rst%0d", i), 0, 1, 32'h6000 + i, 32'h300 + 4 * i, 0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("pre_rst.count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h13, 32'd0, 32'd0, 0, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_cycle("post_rst0", 0, 1, 32'h7000, 32'h400, 0);
        model_cycle("post_rst1", 0, 0, 32'h0, 32'h0, 1);
        model_cycle("post_rst2", 0, 0, 32'h0, 32'h0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pcv;
            pcv = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            model_cycle($sformatf("rnd%0d", i),
                        $urandom_range(0, 15) == 0,
                        $urandom_range(0, 2) != 0,
                        $urandom, pcv,
                        $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #200000;
        numFails++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
